dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data RAM controller between the core load/store unit (M0) and the program-loader/debug port (M1).
- Grants at most one access per cycle and drives the RAM controller's address, data and access-size controls.
- Tracks the 1-cycle read latency and returns read data and rvalid to the requester that issued the read.
- Guarantees M1 forward progress with a starvation counter.

Parameters:
- DEPTH, 4096, RAM depth in words; ADDRWIDTH = $clog2(DEPTH).
- XLEN, 32, data width.
- MAX_WAIT, 8, consecutive cycles M1 may be denied before it takes priority (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  core access request.
- m0_we  in  1  1 = store, 0 = load.
- m0_addr  in  ADDRWIDTH  word address.
- m0_wdata  in  XLEN  store data.
- m0_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- m0_uns  in  1  zero-extend load.
- m0_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  load data valid.
- m0_rdata  out  XLEN  load data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_size, m1_uns, m1_gnt, m1_rvalid, m1_rdata: same as the M0 ports, for M1.
- ram_addr  out  ADDRWIDTH  to controller addr.
- ram_wrData  out  XLEN  to controller wrData.
- ram_wrEn  out  1  to controller wrEn.
- ram_byteEn, ram_halfEn, ram_wordEn, ram_unsignedEn  out  1 each  size/sign controls, one-hot across byte/half/word.
- ram_dataOut  in  XLEN  controller read data, valid the cycle after the address.

Behaviour:
- Reset (async, rst=1): gnt=0 on both ports, rvalid=0, rdata=0, wait counter=0, rd_pending=0. ram_wrEn is forced to 0 while rst=1.
- Grant rule, evaluated per cycle:
  - Only M0 requests → grant M0.
  - Only M1 requests → grant M1.
  - Both request → grant M0 unless wait_cnt ≥ MAX_WAIT, then grant M1.
  - At most one gnt is high per cycle.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle m1_req=1 and m1_gnt=0.
  - Clears on m1_gnt=1 or when m1_req=0.
- RAM drive (combinational from the granted port):
  - ram_addr and ram_wrData come from the granted port.
  - ram_wrEn = granted we.
  - byteEn/halfEn/wordEn decoded from size.
  - unsignedEn = granted uns.
  - With no grant, drive M0's fields with ram_wrEn=0. This is a harmless read whose data is discarded.
- Read tracking registers:
  - On a granted load, set rd_pending=1 and rd_owner=granted port at the clock edge.
  - The next cycle, the owner's rvalid=1 and its rdata=ram_dataOut, already sign/zero-extended by the controller.
  - rvalid is a single-cycle pulse; the non-owner's rvalid stays 0 and its rdata holds its last value.
- Writes complete at the granting edge; there is no response and rd_pending is not set.
- Back-to-back: a new grant may be issued in the same cycle as the previous load's rvalid, giving full throughput of 1 access/cycle.
- Requesters hold req and payload stable until gnt. Dropping req without gnt is legal and issues no access.
- Reset mid-read: a pending read is discarded and no rvalid is produced after reset deassertion.
- Simultaneous M1 starvation and M0 request at saturation: M1 wins exactly once, then the counter clears and M0 priority resumes.

Decomposition:
- Package dmem_pkg holds:
  - enum access_size_t {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10}.
  - A function size_to_en() returning {byteEn, halfEn, wordEn}.
  - localparam port IDs PORT_M0=1'b0, PORT_M1=1'b1.
- A single sub-module, dmem_arb_prio (grant logic plus wait counter), is natural.
- Read tracking and muxing stay in the top level.
- The top instantiates the RAM controller externally; this block does not contain it.

Test Plan:
- Reset: assert rst mid-cycle with m0_req=1 → m0_gnt=0, ram_wrEn=0, both rvalid=0 immediately (asynchronous).
- M0 alone:
  - Store word 0xDEADBEEF at addr 5 → m0_gnt=1, ram_wrEn=1, ram_wordEn=1.
  - Then load word from addr 5 → m0_rvalid=1 exactly one cycle after gnt, with m0_rdata=0xDEADBEEF.
- Extension: load byte from addr 5 (low byte 0xEF) → signed gives 0xFFFFFFEF; m1 with uns=1 gives 0x000000EF on m1_rdata only, and m0_rvalid stays 0.
- Contention: m0_req and m1_req held high for 20 cycles with MAX_WAIT=8 → M0 granted 8 cycles, M1 granted on cycle 9, M0 on cycles 10–17, M1 again on cycle 18.
- Pipelined loads: M0 load addr 1 then M1 load addr 2 on consecutive cycles → m0_rvalid then m1_rvalid on consecutive cycles, each carrying its own word.
- Reset during a pending read: a load is granted, then rst pulses before the next edge → no rvalid after rst deasserts; the next grant behaves normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory arbiter.
//   access_size_t : encoding of the 2-bit access-size field.
//   PORT_M0/M1    : requester IDs used to tag outstanding reads.
//   size_to_en()  : size field -> {byteEn, halfEn, wordEn}, one-hot.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } access_size_t;

   localparam logic PORT_M0 = 1'b0;
   localparam logic PORT_M1 = 1'b1;

   // Encoding 2'b11 is not a legal size and is treated as a word access.
   function automatic logic [2:0] size_to_en(input logic [1:0] size);
      logic [2:0] en;
      if (size == SZ_BYTE)      en = 3'b100;
      else if (size == SZ_HALF) en = 3'b010;
      else                      en = 3'b001;
      return en;
   endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: grant decision between M0 (core) and M1 (loader/debug),
// with a starvation counter guaranteeing M1 forward progress.
//   clk, rst   : clock, asynchronous active-high reset.
//   m0_req_i   : M0 request.
//   m1_req_i   : M1 request.
//   m0_gnt_o   : M0 granted this cycle (combinational, 0 during reset).
//   m1_gnt_o   : M1 granted this cycle (combinational, 0 during reset).
module dmem_arb_prio
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic m0_req_i,
   input  logic m1_req_i,
   output logic m0_gnt_o,
   output logic m1_gnt_o
);

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   logic [7:0] wait_q, wait_d;
   logic       starved;

   assign starved = (wait_q >= MAX_W);

   always_comb begin
      m1_gnt_o = 1'b0;
      m0_gnt_o = 1'b0;
      wait_d   = wait_q;
      if (!rst) begin
         // M0 has priority unless M1 has been denied MAX_WAIT cycles in a row.
         m1_gnt_o = m1_req_i && (!m0_req_i || starved);
         m0_gnt_o = m0_req_i && !m1_gnt_o;
      end
      if (!m1_req_i || m1_gnt_o)
         wait_d = '0;
      else if (wait_q < MAX_W)
         wait_d = wait_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_q <= '0;
      else     wait_q <= wait_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM controller between the core
// load/store unit (M0) and the program-loader/debug port (M1).
//   clk, rst                  : clock, asynchronous active-high reset.
//   mX_req/we/addr/wdata      : request, store flag, word address, store data.
//   mX_size/uns               : access size (00 b, 01 h, 10/11 w), zero-extend.
//   mX_gnt                    : request accepted this cycle (combinational).
//   mX_rvalid/rdata           : load response, one cycle after the grant.
//   ram_addr/wrData/wrEn      : controller address, write data, write enable.
//   ram_byteEn/halfEn/wordEn  : one-hot size controls.
//   ram_unsignedEn            : zero-extend control.
//   ram_dataOut               : controller read data, valid the cycle after addr.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter  int DEPTH     = 4096,
   parameter  int XLEN      = 32,
   parameter  int MAX_WAIT  = 8,
   localparam int ADDRWIDTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic                 m0_we,
   input  logic [ADDRWIDTH-1:0] m0_addr,
   input  logic [XLEN-1:0]      m0_wdata,
   input  logic [1:0]           m0_size,
   input  logic                 m0_uns,
   output logic                 m0_gnt,
   output logic                 m0_rvalid,
   output logic [XLEN-1:0]      m0_rdata,
   input  logic                 m1_req,
   input  logic                 m1_we,
   input  logic [ADDRWIDTH-1:0] m1_addr,
   input  logic [XLEN-1:0]      m1_wdata,
   input  logic [1:0]           m1_size,
   input  logic                 m1_uns,
   output logic                 m1_gnt,
   output logic                 m1_rvalid,
   output logic [XLEN-1:0]      m1_rdata,
   output logic [ADDRWIDTH-1:0] ram_addr,
   output logic [XLEN-1:0]      ram_wrData,
   output logic                 ram_wrEn,
   output logic                 ram_byteEn,
   output logic                 ram_halfEn,
   output logic                 ram_wordEn,
   output logic                 ram_unsignedEn,
   input  logic [XLEN-1:0]      ram_dataOut
);

   logic            any_gnt, sel_we;
   logic [1:0]      sel_size;
   logic            rd_pending_q, rd_pending_d;
   logic            rd_owner_q, rd_owner_d;
   logic [XLEN-1:0] m0_rdata_q, m1_rdata_q;

   dmem_arb_prio #(
      .MAX_WAIT (MAX_WAIT)
   ) u_prio (
      .clk      (clk),
      .rst      (rst),
      .m0_req_i (m0_req),
      .m1_req_i (m1_req),
      .m0_gnt_o (m0_gnt),
      .m1_gnt_o (m1_gnt)
   );

   // With no grant M0's fields are presented as a read whose data is dropped.
   always_comb begin
      any_gnt        = m0_gnt | m1_gnt;
      ram_addr       = m1_gnt ? m1_addr  : m0_addr;
      ram_wrData     = m1_gnt ? m1_wdata : m0_wdata;
      sel_we         = m1_gnt ? m1_we    : m0_we;
      sel_size       = m1_gnt ? m1_size  : m0_size;
      ram_unsignedEn = m1_gnt ? m1_uns   : m0_uns;
      ram_wrEn       = any_gnt & sel_we;   // grants are already 0 during reset
      {ram_byteEn, ram_halfEn, ram_wordEn} = size_to_en(sel_size);
      rd_pending_d   = any_gnt & ~sel_we;
      rd_owner_d     = m1_gnt ? PORT_M1 : PORT_M0;
   end

   // Response path: controller data flows straight through on the rvalid
   // cycle and is captured so the port keeps showing it afterwards.
   always_comb begin
      m0_rvalid = rd_pending_q && (rd_owner_q == PORT_M0);
      m1_rvalid = rd_pending_q && (rd_owner_q == PORT_M1);
      m0_rdata  = m0_rvalid ? ram_dataOut : m0_rdata_q;
      m1_rdata  = m1_rvalid ? ram_dataOut : m1_rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending_q <= 1'b0;
         rd_owner_q   <= PORT_M0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
         m0_rdata_q   <= m0_rdata;
         m1_rdata_q   <= m1_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int DEPTH    = 4096;
   localparam int AW       = 12;
   localparam int MAX_WAIT = 8;

   logic          clk, rst;
   logic          m0_req, m0_we, m0_uns, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [31:0]   m0_wdata, m0_rdata;
   logic [1:0]    m0_size;
   logic          m1_req, m1_we, m1_uns, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [31:0]   m1_wdata, m1_rdata;
   logic [1:0]    m1_size;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wrData, ram_dataOut;
   logic          ram_wrEn, ram_byteEn, ram_halfEn, ram_wordEn, ram_unsignedEn;

   int checks = 0;
   int fails  = 0;

   dmem_arbiter #(.DEPTH(DEPTH), .XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_size(m0_size), .m0_uns(m0_uns), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_size(m1_size), .m1_uns(m1_uns), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_wrData(ram_wrData), .ram_wrEn(ram_wrEn),
      .ram_byteEn(ram_byteEn), .ram_halfEn(ram_halfEn), .ram_wordEn(ram_wordEn),
      .ram_unsignedEn(ram_unsignedEn), .ram_dataOut(ram_dataOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz,
                                       input logic uns);
      case (sz)
         2'b00:   return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'b01:   return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // RAM controller stand-in: 1-cycle read latency, extension done here.
   logic [31:0] cmem [DEPTH] = '{default: '0};
   always @(posedge clk) begin
      if (ram_wrEn) cmem[ram_addr] <= ram_wrData;
      ram_dataOut <= ext(cmem[ram_addr],
                         ram_byteEn ? 2'b00 : (ram_halfEn ? 2'b01 : 2'b10),
                         ram_unsignedEn);
   end

   // Transaction-level model: decides grants from the rules, keeps its own
   // memory image and the one outstanding read, and checks every cycle.
   logic [31:0] mmem [DEPTH] = '{default: '0};
   int          denied;
   bit          exp_pend, exp_owner;
   logic [31:0] exp_val, exp_r0, exp_r1;

   always @(negedge clk or posedge rst) begin
      bit g0, g1, v0, v1, we, uns;
      logic [AW-1:0] a;
      logic [31:0]   wd;
      logic [1:0]    sz;
      logic [2:0]    en;
      if (rst) begin
         denied = 0; exp_pend = 0; exp_owner = 0;
         exp_r0 = '0; exp_r1 = '0; exp_val = '0;
      end else begin
         g1 = m1_req && (!m0_req || denied >= MAX_WAIT);
         g0 = m0_req && !g1;
         check("m0_gnt", 32'(m0_gnt), 32'(g0));
         check("m1_gnt", 32'(m1_gnt), 32'(g1));
         v0 = exp_pend && !exp_owner;
         v1 = exp_pend && exp_owner;
         if (v0) exp_r0 = exp_val;
         if (v1) exp_r1 = exp_val;
         check("m0_rvalid", 32'(m0_rvalid), 32'(v0));
         check("m1_rvalid", 32'(m1_rvalid), 32'(v1));
         check("m0_rdata", m0_rdata, exp_r0);
         check("m1_rdata", m1_rdata, exp_r1);
         if (g1) begin a = m1_addr; wd = m1_wdata; sz = m1_size; uns = m1_uns; we = m1_we; end
         else    begin a = m0_addr; wd = m0_wdata; sz = m0_size; uns = m0_uns; we = m0_we; end
         if (g0 || g1) begin
            en = (sz == 2'b00) ? 3'b100 : ((sz == 2'b01) ? 3'b010 : 3'b001);
            check("ram_addr", 32'(ram_addr), 32'(a));
            check("ram_wrEn", 32'(ram_wrEn), 32'(we));
            check("ram_en", 32'({ram_byteEn, ram_halfEn, ram_wordEn}), 32'(en));
            check("ram_uns", 32'(ram_unsignedEn), 32'(uns));
            if (we) check("ram_wrData", ram_wrData, wd);
         end else begin
            check("idle_wrEn", 32'(ram_wrEn), 32'd0);
            check("idle_addr", 32'(ram_addr), 32'(m0_addr));
         end
         // effect of the coming clock edge
         if ((g0 || g1) && we) mmem[a] = wd;
         exp_pend = (g0 || g1) && !we;
         if (exp_pend) begin
            exp_owner = g1;
            exp_val   = ext(mmem[a], sz, uns);
         end
         if (m1_req && !g1) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
         else               denied = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_size = 2'b10; m0_uns = 0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_size = 2'b10; m1_uns = 0;
   endtask

   task automatic m0_set(input bit we, input int a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns);
      m0_req = 1; m0_we = we; m0_addr = AW'(a); m0_wdata = wd; m0_size = sz; m0_uns = uns;
   endtask

   task automatic m1_set(input bit we, input int a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns);
      m1_req = 1; m1_we = we; m1_addr = AW'(a); m1_wdata = wd; m1_size = sz; m1_uns = uns;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1;
      repeat (2) cyc();
      check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      check("rst_m1_rdata", m1_rdata, 32'h0);
      rst = 0;
      cyc();

      // asynchronous reset asserted mid-cycle over a pending store request
      m0_set(1, 9, 32'h99, 2'b10, 0);
      #1 check("pre_rst_gnt", 32'(m0_gnt), 32'd1);
      rst = 1;
      #1;
      check("rst_async_gnt", 32'(m0_gnt), 32'd0);
      check("rst_async_wrEn", 32'(ram_wrEn), 32'd0);
      check("rst_async_rv", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      cyc();
      idle();
      rst = 0;
      cyc();

      // M0 word store then load
      m0_set(1, 5, 32'hDEADBEEF, 2'b10, 0);
      #1;
      check("st_gnt", 32'(m0_gnt), 32'd1);
      check("st_wrEn", 32'(ram_wrEn), 32'd1);
      check("st_wordEn", 32'(ram_wordEn), 32'd1);
      cyc();
      m0_set(0, 5, '0, 2'b10, 0);
      cyc();
      idle();
      #1;
      check("ld_rvalid", 32'(m0_rvalid), 32'd1);
      check("ld_rdata", m0_rdata, 32'hDEADBEEF);
      cyc();
      check("ld_pulse", 32'(m0_rvalid), 32'd0);

      // byte loads: signed on M0, unsigned on M1
      m0_set(0, 5, '0, 2'b00, 0);
      cyc();
      idle();
      #1 check("lb_signed", m0_rdata, 32'hFFFFFFEF);
      cyc();
      m1_set(0, 5, '0, 2'b00, 1);
      cyc();
      idle();
      #1;
      check("lbu_m1_rv", 32'(m1_rvalid), 32'd1);
      check("lbu_m1", m1_rdata, 32'h000000EF);
      check("lbu_m0_rv", 32'(m0_rvalid), 32'd0);
      check("lbu_m0_hold", m0_rdata, 32'hFFFFFFEF);
      cyc();

      // pipelined loads from both ports
      m1_set(1, 1, 32'h11111111, 2'b10, 0);
      cyc();
      m1_set(1, 2, 32'h22222222, 2'b10, 0);
      cyc();
      idle();
      m0_set(0, 1, '0, 2'b10, 0);
      cyc();
      idle();
      m1_set(0, 2, '0, 2'b10, 0);
      #1;
      check("pipe_m0_rv", 32'(m0_rvalid), 32'd1);
      check("pipe_m0", m0_rdata, 32'h11111111);
      check("pipe_m1_gnt", 32'(m1_gnt), 32'd1);
      cyc();
      idle();
      #1;
      check("pipe_m1_rv", 32'(m1_rvalid), 32'd1);
      check("pipe_m1", m1_rdata, 32'h22222222);
      check("pipe_m0_rv2", 32'(m0_rvalid), 32'd0);
      cyc();

      // contention: M1 wins on cycles 9 and 18 (indices 8 and 17)
      m0_set(0, 1, '0, 2'b10, 0);
      m1_set(0, 2, '0, 2'b10, 0);
      for (int i = 0; i < 20; i++) begin
         #1 check($sformatf("cont_m1_gnt[%0d]", i), 32'(m1_gnt),
                  32'((i == 8) || (i == 17)));
         cyc();
      end
      idle();
      cyc();
      cyc();

      // reset pulse while a load is outstanding
      m0_set(0, 1, '0, 2'b10, 0);
      cyc();
      idle();
      #1 rst = 1;
      #1 rst = 0;
      #1 check("rst_pend_rv", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      cyc();
      check("rst_pend_rv2", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      m0_set(0, 2, '0, 2'b10, 0);
      cyc();
      idle();
      #1;
      check("post_rst_rv", 32'(m0_rvalid), 32'd1);
      check("post_rst_data", m0_rdata, 32'h22222222);
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
